// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation codes, forwarding
// selects and result-source encodings used by decode and execute.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  // Forwarding mux selects; 2'b11 is unused and behaves like FWD_RF
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Writeback result source
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational integer ALU for the execute stage. Carries and overflow
// are discarded; unsupported operation codes produce zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   lt_s;

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = (a_s < b_s);

  // Operation select
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt_s};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: ID/EX register, forwarding muxes, ALU, branch
// target adder and EX/MEM register. A stalled instruction stays in ID/EX
// while a control bubble enters EX/MEM so it retires exactly once.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_e,
  input  logic            stall_e,
  input  logic            reg_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic            alu_src_d,
  input  logic [2:0]      alu_control_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [RAW-1:0]  rs1_d,
  input  logic [RAW-1:0]  rs2_d,
  input  logic [RAW-1:0]  rd_d,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic [RAW-1:0]  rs1_e,
  output logic [RAW-1:0]  rs2_e,
  output logic [RAW-1:0]  rd_e,
  output logic            result_src_e0,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            reg_write_m,
  output logic [1:0]      result_src_m,
  output logic            mem_write_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [RAW-1:0]  rd_m,
  output logic [XLEN-1:0] pc_plus4_m
);

  logic            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;

  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic            zero_e, hold_e;

  // Operand forwarding; unused select 2'b11 falls back to the register file
  function automatic logic [XLEN-1:0] fwd(input logic [1:0]      sel,
                                          input logic [XLEN-1:0] rf,
                                          input logic [XLEN-1:0] w,
                                          input logic [XLEN-1:0] m);
    case (sel)
      FWD_W:   return w;
      FWD_M:   return m;
      default: return rf;
    endcase
  endfunction

  // ---- ID/EX boundary ----
  // ID/EX register: flush beats stall, stall beats load
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush_e) begin
      reg_write_e   <= 1'b0;
      result_src_e  <= RES_ALU;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      pc_plus4_e    <= '0;
      imm_ext_e     <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
    end else if (!stall_e) begin
      reg_write_e   <= reg_write_d;
      result_src_e  <= result_src_d;
      mem_write_e   <= mem_write_d;
      jump_e        <= jump_d;
      branch_e      <= branch_d;
      alu_src_e     <= alu_src_d;
      alu_control_e <= alu_control_d;
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      pc_e          <= pc_d;
      pc_plus4_e    <= pc_plus4_d;
      imm_ext_e     <= imm_ext_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
    end
  end

  // ---- EX combinational ----
  assign src_a_e      = fwd(forward_a_e, rd1_e, result_w, alu_result_m);
  assign write_data_e = fwd(forward_b_e, rd2_e, result_w, alu_result_m);
  assign src_b_e      = alu_src_e ? imm_ext_e : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (src_a_e),
    .b      (src_b_e),
    .op     (alu_op_t'(alu_control_e)),
    .result (alu_result_e),
    .zero   (zero_e)
  );

  assign pc_target_e   = pc_e + imm_ext_e;
  assign pc_src_e      = (branch_e & zero_e) | jump_e;
  assign result_src_e0 = result_src_e[0];

  // A held instruction must not also commit side effects from EX/MEM
  assign hold_e = stall_e & ~flush_e;

  // ---- EX/MEM boundary ----
  // EX/MEM register: loads every cycle, control squashed while ID/EX holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      result_src_m <= RES_ALU;
      mem_write_m  <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
    end else begin
      reg_write_m  <= reg_write_e & ~hold_e;
      result_src_m <= hold_e ? RES_ALU : result_src_e;
      mem_write_m  <= mem_write_e & ~hold_e;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      rd_m         <= rd_e;
      pc_plus4_m   <= pc_plus4_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: expected EX/MEM records are queued
// when an instruction is driven and compared when it reaches the M outputs.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_e, stall_e;
  logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] result_w;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        result_src_e0, pc_src_e;
  logic [31:0] pc_target_e;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] pc4;
  } mrec_t;

  mrec_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  execute_stage #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .reset(reset), .flush_e(flush_e), .stall_e(stall_e),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
    .jump_d(jump_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
    .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_src_e0(result_src_e0), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .mem_write_m(mem_write_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
    .pc_plus4_m(pc_plus4_m)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_d = 0; result_src_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0;
    alu_src_d = 0; alu_control_d = 0; rd1_d = 0; rd2_d = 0; pc_d = 0; pc_plus4_d = 0;
    imm_ext_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
    flush_e = 0; stall_e = 0; forward_a_e = 0; forward_b_e = 0; result_w = 0;
  endtask

  task automatic set_instr(input logic rw, input logic [1:0] rs, input logic mw,
                           input logic jmp, input logic br, input logic asrc,
                           input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    reg_write_d = rw; result_src_d = rs; mem_write_d = mw; jump_d = jmp; branch_d = br;
    alu_src_d = asrc; alu_control_d = ctl; rd1_d = a; rd2_d = b; imm_ext_d = imm;
    pc_d = pc; pc_plus4_d = pc + 32'd4; rd_d = rd; rs1_d = rd ^ 5'h01; rs2_d = rd ^ 5'h02;
  endtask

  function automatic mrec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                               input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [31:0] pc4);
    mrec_t r;
    r = '{alu: alu, wd: wd, rd: rd, rw: rw, mw: mw, rs: rs, pc4: pc4};
    return r;
  endfunction

  function automatic mrec_t m_now();
    return {alu_result_m, write_data_m, rd_m, reg_write_m, mem_write_m, result_src_m, pc_plus4_m};
  endfunction

  // An empty queue yields all-X so the comparison cannot silently pass
  function automatic mrec_t pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  function automatic logic [153:0] all_out();
    return {rs1_e, rs2_e, rd_e, result_src_e0, pc_src_e, pc_target_e, reg_write_m,
            result_src_m, mem_write_m, alu_result_m, write_data_m, rd_m, pc_plus4_m};
  endfunction

  task automatic test_reset();
    mrec_t e;
    logic [153:0] o;
    set_instr(1, 2'b10, 1, 1, 1, 1, 3'b000, 32'h11, 32'h22, 32'h10, 32'h100, 5'd9);
    tick(); tick();
    o = all_out();
    n_chk++;
    if (o !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", o);
    end
    idle();
    tick();
    reset = 0;
    e = '0;
    tick();
    n_chk++;
    if (m_now() !== e) begin
      n_fail++; $display("FAIL reset_idle_m got=%h exp=%h", m_now(), e);
    end
  endtask

  task automatic test_add();
    mrec_t e;
    set_instr(1, 2'b00, 0, 0, 1, 0, 3'b000, 32'd5, 32'd7, 32'd0, 32'h40, 5'd3);
    sb.push_back(mk(32'd12, 32'd7, 5'd3, 1, 0, 2'b00, 32'h44));
    tick();
    n_chk++;
    if (rd_e !== 5'd3) begin n_fail++; $display("FAIL add_rd_e got=%0d exp=3", rd_e); end
    n_chk++;
    if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL add_zero got=%b exp=0", pc_src_e); end
    idle();
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL add_m got=%h exp=%h", m_now(), e); end
  endtask

  task automatic test_forward();
    mrec_t e;
    // producer leaves 20 in alu_result_m for the following sub
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd20, 32'd0, 32'd0, 32'h50, 5'd4);
    sb.push_back(mk(32'd20, 32'd0, 5'd4, 1, 0, 2'b00, 32'h54));
    tick();
    set_instr(1, 2'b00, 0, 0, 1, 0, 3'b001, 32'd999, 32'd20, 32'd0, 32'h60, 5'd5);
    sb.push_back(mk(32'd0, 32'd20, 5'd5, 1, 0, 2'b00, 32'h64));
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL fwd_prod_m got=%h exp=%h", m_now(), e); end
    forward_a_e = 2'b10;
    #1;
    n_chk++;
    if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL fwd_m_zero got=%b exp=1", pc_src_e); end
    set_instr(0, 2'b00, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL fwd_sub_m got=%h exp=%h", m_now(), e); end
    // B from writeback: ALU and write data both see result_w
    forward_a_e = 2'b00;
    set_instr(1, 2'b00, 1, 0, 0, 0, 3'b000, 32'd1, 32'd5, 32'd0, 32'h80, 5'd6);
    sb.push_back(mk(32'h1001, 32'h1000, 5'd6, 1, 1, 2'b00, 32'h84));
    tick();
    forward_b_e = 2'b01; result_w = 32'h1000;
    set_instr(0, 2'b00, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL fwd_w_m got=%h exp=%h", m_now(), e); end
    // select 11 behaves as the register-file path
    idle();
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd7, 32'd1, 32'd0, 32'h90, 5'd7);
    sb.push_back(mk(32'd8, 32'd1, 5'd7, 1, 0, 2'b00, 32'h94));
    tick();
    forward_a_e = 2'b11; forward_b_e = 2'b11; result_w = 32'hDEAD;
    set_instr(0, 2'b00, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL fwd_11_m got=%h exp=%h", m_now(), e); end
    idle();
  endtask

  task automatic test_back_to_back();
    mrec_t e;
    logic [2:0]  tc[10] = '{3'b101, 3'b101, 3'b010, 3'b011, 3'b100, 3'b111, 3'b001, 3'b000, 3'b101, 3'b110};
    logic [31:0] ta[10] = '{32'hFFFF_FFFF, 32'd1, 32'hF0F0, 32'hF0F0, 32'd5, 32'd5, 32'd0, 32'd10,
                            32'h8000_0000, 32'd9};
    logic [31:0] tb[10] = '{32'd1, 32'hFFFF_FFFF, 32'hFF00, 32'hFF00, 32'd3, 32'd3, 32'd1, 32'd77,
                            32'h7FFF_FFFF, 32'd4};
    logic [31:0] ti[10] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 32'd0};
    logic        ts[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] tx[10] = '{32'd1, 32'd0, 32'hF000, 32'hFFF0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd8,
                            32'd1, 32'd0};
    for (int i = 0; i < 10; i++) begin
      set_instr(i[0], 2'(i % 3), i[1], 0, 0, ts[i], tc[i], ta[i], tb[i], ti[i],
                32'h200 + 32'(4 * i), 5'(8 + i));
      sb.push_back(mk(tx[i], tb[i], 5'(8 + i), i[0], i[1], 2'(i % 3), 32'h204 + 32'(4 * i)));
      tick();
      if (i > 0) begin
        e = pop_exp();
        n_chk++;
        if (m_now() !== e) begin n_fail++; $display("FAIL b2b_%0d got=%h exp=%h", i - 1, m_now(), e); end
      end
    end
    idle();
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL b2b_9 got=%h exp=%h", m_now(), e); end
  endtask

  task automatic test_branch();
    set_instr(0, 2'b00, 0, 0, 1, 0, 3'b001, 32'd3, 32'd3, 32'h10, 32'h100, 5'h0A);
    tick();
    n_chk++;
    if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL beq_taken got=%b exp=1", pc_src_e); end
    n_chk++;
    if (pc_target_e !== 32'h110) begin n_fail++; $display("FAIL beq_target got=%h exp=110", pc_target_e); end
    n_chk++;
    if ({rs1_e, rs2_e} !== {5'h0B, 5'h08}) begin
      n_fail++; $display("FAIL beq_rs got=%h/%h exp=0b/08", rs1_e, rs2_e);
    end
    set_instr(0, 2'b00, 0, 0, 1, 0, 3'b001, 32'd3, 32'd4, 32'h10, 32'h100, 5'h0A);
    tick();
    n_chk++;
    if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got=%b exp=0", pc_src_e); end
    set_instr(1, 2'b01, 0, 1, 0, 0, 3'b000, 32'd1, 32'd2, 32'h20, 32'h300, 5'd1);
    tick();
    n_chk++;
    if (pc_src_e !== 1'b1) begin n_fail++; $display("FAIL jal_taken got=%b exp=1", pc_src_e); end
    n_chk++;
    if (pc_target_e !== 32'h320) begin n_fail++; $display("FAIL jal_target got=%h exp=320", pc_target_e); end
    n_chk++;
    if (result_src_e0 !== 1'b1) begin n_fail++; $display("FAIL res_src_e0 got=%b exp=1", result_src_e0); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    mrec_t e;
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd1, 32'd2, 32'd0, 32'h400, 5'd5);
    sb.push_back(mk(32'd3, 32'd2, 5'd5, 1, 0, 2'b00, 32'h404));
    tick();
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd4, 32'd4, 32'd0, 32'h408, 5'd7);
    flush_e = 1;
    sb.push_back('0);
    tick();
    n_chk++;
    if (rd_e !== 5'd0) begin n_fail++; $display("FAIL flush_rd_e got=%0d exp=0", rd_e); end
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL flush_prev_m got=%h exp=%h", m_now(), e); end
    idle();
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL flush_bubble_m got=%h exp=%h", m_now(), e); end
    // flush together with stall: the bubble still enters ID/EX
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b001, 32'd6, 32'd1, 32'd0, 32'h410, 5'd9);
    sb.push_back(mk(32'd5, 32'd1, 5'd9, 1, 0, 2'b00, 32'h414));
    tick();
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd4, 32'd4, 32'd0, 32'h418, 5'd11);
    flush_e = 1; stall_e = 1;
    sb.push_back('0);
    tick();
    n_chk++;
    if (rd_e !== 5'd0) begin n_fail++; $display("FAIL flush_stall_rd_e got=%0d exp=0", rd_e); end
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL flush_stall_m got=%h exp=%h", m_now(), e); end
    idle();
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL flush_stall_bub got=%h exp=%h", m_now(), e); end
  endtask

  task automatic test_stall();
    mrec_t e;
    logic [3:0] ctl;
    set_instr(1, 2'b01, 1, 0, 0, 0, 3'b011, 32'h0F, 32'hF0, 32'd0, 32'h500, 5'd12);
    tick();
    set_instr(1, 2'b00, 0, 0, 0, 0, 3'b000, 32'd2, 32'd3, 32'd0, 32'h504, 5'd13);
    stall_e = 1;
    tick();
    n_chk++;
    if (rd_e !== 5'd12) begin n_fail++; $display("FAIL stall_hold got=%0d exp=12", rd_e); end
    ctl = {reg_write_m, mem_write_m, result_src_m};
    n_chk++;
    if (ctl !== 4'b0000) begin n_fail++; $display("FAIL stall_bubble_ctl got=%b exp=0000", ctl); end
    stall_e = 0;
    sb.push_back(mk(32'hFF, 32'hF0, 5'd12, 1, 1, 2'b01, 32'h504));
    tick();
    n_chk++;
    if (rd_e !== 5'd13) begin n_fail++; $display("FAIL stall_next got=%0d exp=13", rd_e); end
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL stall_held_m got=%h exp=%h", m_now(), e); end
    idle();
    sb.push_back(mk(32'd5, 32'd3, 5'd13, 1, 0, 2'b00, 32'h508));
    tick();
    e = pop_exp();
    n_chk++;
    if (m_now() !== e) begin n_fail++; $display("FAIL stall_follow_m got=%h exp=%h", m_now(), e); end
  endtask

  task automatic test_reset_mid();
    logic [153:0] o;
    set_instr(1, 2'b01, 1, 0, 0, 0, 3'b000, 32'd1, 32'd1, 32'd8, 32'h600, 5'd3);
    tick();
    set_instr(1, 2'b00, 0, 1, 0, 0, 3'b000, 32'd2, 32'd2, 32'd4, 32'h700, 5'd4);
    tick();
    #2;
    reset = 1;
    #1;
    o = all_out();
    n_chk++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_mid got=%h exp=0", o); end
    idle();
    tick();
    reset = 0;
    sb.delete();
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_add();
    test_forward();
    test_back_to_back();
    test_branch();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
